// File: rtl/seq_divider_8_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the quotient value reported for a divide by zero.
package seq_divider_8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    // Wide all-ones pattern; sized down to the operand width where it is used
    localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_8_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor and either keep the difference or restore.
module div_step
    import seq_divider_8_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qBit
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    assign w_trial = {i_rem, i_bit};

    // Subtract as a + ~b + 1. The kept remainder is always below the divisor,
    // so a non-negative difference never reaches bit WIDTH; that bit is therefore
    // the borrow-out and selects the restore path.
    assign w_diff = w_trial + ~{1'b0, i_divisor} + (WIDTH + 1)'(1);

    assign o_qBit = ~w_diff[WIDTH];
    assign o_rem  = o_qBit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider_8.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock,
// with a single-cycle done pulse and a divide-by-zero shortcut.
module seq_divider_8
    import seq_divider_8_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_nextState;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_shiftQ;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_divByZero;

    logic [WIDTH-1:0] w_stepRem;
    logic             w_qBit;
    logic             w_lastStep;

    assign w_lastStep = (r_count == CW'(WIDTH - 1));

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_bit    (r_shiftQ[WIDTH-1]),
        .i_divisor(r_divisor),
        .o_rem    (w_stepRem),
        .o_qBit   (w_qBit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = (divisor == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_lastStep) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Result registers only move on completion so they hold across a new request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divisor   <= '0;
            r_rem       <= '0;
            r_shiftQ    <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divByZero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (divisor != '0)) begin
                        r_divisor <= divisor;
                        r_rem     <= '0;
                        r_shiftQ  <= dividend;
                        r_count   <= '0;
                    end else if (start) begin
                        r_quotient  <= WIDTH'(DBZ_QUOTIENT);
                        r_remainder <= dividend;
                        r_divByZero <= 1'b1;
                    end
                end
                ST_CALC: begin
                    r_rem    <= w_stepRem;
                    r_shiftQ <= {r_shiftQ[WIDTH-2:0], w_qBit};
                    r_count  <= r_count + CW'(1);
                    if (w_lastStep) begin
                        r_quotient  <= {r_shiftQ[WIDTH-2:0], w_qBit};
                        r_remainder <= w_stepRem;
                        r_divByZero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_seq_divider_8.sv
// Self-checking bench for seq_divider_8: directed boundary cases, reset and
// start-while-busy scenarios, then random operands against an arithmetic model.
module tb_seq_divider_8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider_8 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference model: plain integer division, with the divide-by-zero rule
    function automatic void refDivide(input logic [7:0] a, input logic [7:0] b,
                                      output logic [7:0] q, output logic [7:0] r,
                                      output logic z);
        if (b == 8'd0) begin
            q = 8'd255;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Issue one request and wait (bounded) for done; reports edges after acceptance
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 output int edges, output bit holdOk);
        logic [7:0] prevQ;
        logic [7:0] prevR;
        logic       prevZ;
        @(negedge clk);
        prevQ    = quotient;
        prevR    = remainder;
        prevZ    = div_by_zero;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        edges    = 0;
        holdOk   = 1'b1;
        while (done !== 1'b1 && edges < 20) begin
            if (quotient !== prevQ || remainder !== prevR || div_by_zero !== prevZ)
                holdOk = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic checkResult(input logic [7:0] a, input logic [7:0] b,
                               input int edges, input bit holdOk);
        logic [7:0] expQ;
        logic [7:0] expR;
        logic       expZ;
        string      tag;
        refDivide(a, b, expQ, expR, expZ);
        tag = $sformatf("%0d/%0d", a, b);
        checkOutput({tag, " latency"}, edges, (b == 8'd0) ? 0 : 8);
        checkOutput({tag, " quotient"}, quotient, expQ);
        checkOutput({tag, " remainder"}, remainder, expR);
        checkOutput({tag, " div_by_zero"}, div_by_zero, expZ);
        checkOutput({tag, " busy_at_done"}, busy, 1);
        checkOutput({tag, " hold_before_done"}, holdOk, 1);
        @(posedge clk);
        #1;
        checkOutput({tag, " done_drops"}, done, 0);
        checkOutput({tag, " busy_drops"}, busy, 0);
    endtask

    initial begin
        int         edges;
        bit         holdOk;
        int         doneCount;
        int         doneAt[$];
        logic [7:0] a;
        logic [7:0] b;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset quotient", quotient, 0);
        checkOutput("reset remainder", remainder, 0);
        checkOutput("reset dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] nominal and boundary cases");
        applyStimulus(8'd100, 8'd7, edges, holdOk);  checkResult(8'd100, 8'd7, edges, holdOk);
        applyStimulus(8'd255, 8'd1, edges, holdOk);  checkResult(8'd255, 8'd1, edges, holdOk);
        applyStimulus(8'd255, 8'd255, edges, holdOk); checkResult(8'd255, 8'd255, edges, holdOk);
        applyStimulus(8'd5, 8'd200, edges, holdOk);  checkResult(8'd5, 8'd200, edges, holdOk);
        applyStimulus(8'd0, 8'd3, edges, holdOk);    checkResult(8'd0, 8'd3, edges, holdOk);
        applyStimulus(8'd254, 8'd127, edges, holdOk); checkResult(8'd254, 8'd127, edges, holdOk);

        $display("[TB] divide by zero then recovery");
        applyStimulus(8'd77, 8'd0, edges, holdOk);   checkResult(8'd77, 8'd0, edges, holdOk);
        applyStimulus(8'd9, 8'd2, edges, holdOk);    checkResult(8'd9, 8'd2, edges, holdOk);

        $display("[TB] reset during calculation");
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset done", done, 0);
        checkOutput("midreset quotient", quotient, 0);
        checkOutput("midreset remainder", remainder, 0);
        checkOutput("midreset dbz", div_by_zero, 0);
        doneCount = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneCount++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneCount++;
        end
        checkOutput("midreset no_done", doneCount, 0);
        applyStimulus(8'd200, 8'd3, edges, holdOk);  checkResult(8'd200, 8'd3, edges, holdOk);

        $display("[TB] start while busy is ignored");
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            edges++;
        end
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(posedge clk);
        #1;
        edges++;
        start = 1'b0;
        while (done !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("busy_start latency", edges, 8);
        checkOutput("busy_start quotient", quotient, 14);
        checkOutput("busy_start remainder", remainder, 2);
        doneCount = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneCount++;
        end
        checkOutput("busy_start no_extra_done", doneCount, 0);

        $display("[TB] held start gives one result per ten cycles");
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd20;
        divisor  = 8'd6;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneAt.push_back(c);
        end
        start = 1'b0;
        checkOutput("held done_count", doneAt.size(), 3);
        checkOutput("held first_done", doneAt[0], 9);
        checkOutput("held period1", doneAt[1] - doneAt[0], 10);
        checkOutput("held period2", doneAt[2] - doneAt[1], 10);
        checkOutput("held quotient", quotient, 3);
        checkOutput("held remainder", remainder, 2);
        repeat (12) @(posedge clk);

        $display("[TB] random operands");
        for (int i = 0; i < 250; i++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            applyStimulus(a, b, edges, holdOk);
            checkResult(a, b, edges, holdOk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
